// File: rtl/johnson_decoder.sv
// johnson_decoder
//
// Receive-side checker and decoder for a WIDTH-bit Johnson (twisted-ring)
// counter code. Each word sampled with in_valid is decoded to its phase index.
// The block flags illegal words and out-of-sequence steps, and it tracks a
// lock status for the incoming stream.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   in_code is sampled on a rising edge where this is 1
//   in_code    Johnson-coded word, WIDTH bits
//   out_valid  one-cycle pulse per sampled word (1 cycle latency)
//   out_index  decoded phase 0..2*WIDTH-1 (0 for illegal words); holds when idle
//   code_err   pulse with out_valid: word is not a legal Johnson code
//   seq_err    pulse with out_valid: legal word, but not a hold or +1 step
//   locked     level: LOCK_COUNT consecutive good steps without error
//   err_count  saturating (255) count of errored samples, cleared by reset only
module johnson_decoder #(
  parameter  int WIDTH      = 4,
  parameter  int LOCK_COUNT = 4,
  localparam int IW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  output logic             out_valid,
  output logic [IW-1:0]    out_index,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int NPH = 2 * WIDTH;
  localparam int KW  = IW + 1;
  localparam int RW  = 4;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [RW-1:0]    RUN_MAX = RW'(LOCK_COUNT);
  localparam logic [IW-1:0]    IDX_MAX = IW'(NPH - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t      state_q, state_d;
  logic [IW-1:0]    ref_q, ref_d;
  logic             ref_valid_q, ref_valid_d;
  logic [RW-1:0]    run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    out_index_q, out_index_d;
  logic             code_err_q, code_err_d;
  logic             seq_err_q, seq_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [KW-1:0]    ones;
  logic [WIDTH-1:0] inv_code;
  logic             legal;
  logic [KW-1:0]    dec_wide;
  logic [IW-1:0]    dec_idx;
  logic [IW-1:0]    ref_plus;
  logic [RW-1:0]    run_inc;

  // Decode. A word whose ones are contiguous from the LSB satisfies
  // x & (x+1) == 0. When the MSB is set, the complement must have that form
  // (ones contiguous from the MSB). The index comes from the popcount.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + KW'(in_code[i]);
    end
    inv_code = ~in_code;
    if (!in_code[WIDTH-1]) begin
      legal    = ((in_code & (in_code + ONE)) == '0);
      dec_wide = ones;
    end else begin
      legal    = ((inv_code & (inv_code + ONE)) == '0);
      dec_wide = KW'(NPH) - ones;
    end
    dec_idx = dec_wide[IW-1:0];
  end

  // Expected next phase, wrapping from the last phase to 0. Also the
  // saturating run increment.
  always_comb begin
    ref_plus = (ref_q == IDX_MAX) ? '0 : ref_q + IW'(1);
    run_inc  = (run_q >= RUN_MAX) ? run_q : run_q + RW'(1);
  end

  // Next-state logic for the reference, the run counter, the lock FSM and the
  // registered outputs. An idle cycle changes nothing except clearing pulses.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    run_d       = run_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    code_err_d  = 1'b0;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      out_valid_d = 1'b1;
      if (!legal) begin
        code_err_d  = 1'b1;
        out_index_d = '0;
        ref_valid_d = 1'b0;
        run_d       = '0;
        state_d     = UNLOCKED;
        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      end else begin
        out_index_d = dec_idx;
        if (!ref_valid_q) begin
          // First legal word after reset or a code error only sets the reference.
          ref_d       = dec_idx;
          ref_valid_d = 1'b1;
        end else if (dec_idx == ref_q) begin
          ref_d = ref_q;
        end else if (dec_idx == ref_plus) begin
          ref_d = dec_idx;
          run_d = run_inc;
          if (run_inc == RUN_MAX) begin
            state_d = LOCKED;
          end
        end else begin
          // Resynchronise to the new phase so a single skip is reported once.
          seq_err_d   = 1'b1;
          ref_d       = dec_idx;
          run_d       = '0;
          state_d     = UNLOCKED;
          err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder
//
// Bench for johnson_decoder at WIDTH=4. Two instances share the stimulus: one
// with LOCK_COUNT=4 (fully checked) and one with LOCK_COUNT=1 (lock level
// checked). Expected records are queued as words are driven and compared one
// cycle later.
module tb_johnson_decoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_code;

  logic       out_valid_a, code_err_a, seq_err_a, locked_a;
  logic [2:0] out_index_a;
  logic [7:0] err_count_a;

  logic       out_valid_b, code_err_b, seq_err_b, locked_b;
  logic [2:0] out_index_b;
  logic [7:0] err_count_b;

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .out_valid (out_valid_a),
    .out_index (out_index_a),
    .code_err  (code_err_a),
    .seq_err   (seq_err_a),
    .locked    (locked_a),
    .err_count (err_count_a)
  );

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(1)) dut_lc1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .out_valid (out_valid_b),
    .out_index (out_index_b),
    .code_err  (code_err_b),
    .seq_err   (seq_err_b),
    .locked    (locked_b),
    .err_count (err_count_b)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic       exp_valid;
    int         exp_idx;
    logic       exp_cerr;
    logic       exp_serr;
    logic       exp_lock;
    logic       exp_lock_b;
    int         exp_errc;
  } vec_t;

  int   checks;
  int   errors;
  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [3:0] c, logic ov, int idx,
                              logic ce, logic se, logic lk, logic lkb, int ec);
    vec_t r;
    r.valid      = v;
    r.code       = c;
    r.exp_valid  = ov;
    r.exp_idx    = idx;
    r.exp_cerr   = ce;
    r.exp_serr   = se;
    r.exp_lock   = lk;
    r.exp_lock_b = lkb;
    r.exp_errc   = ec;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a record");
      return;
    end
    e = exp_q.pop_front();
    cmp("out_valid", 32'(out_valid_a), 32'(e.exp_valid));
    cmp("out_index", 32'(out_index_a), 32'(e.exp_idx));
    cmp("code_err",  32'(code_err_a),  32'(e.exp_cerr));
    cmp("seq_err",   32'(seq_err_a),   32'(e.exp_serr));
    cmp("locked",    32'(locked_a),    32'(e.exp_lock));
    cmp("err_count", 32'(err_count_a), 32'(e.exp_errc));
    cmp("locked_lc1", 32'(locked_b),   32'(e.exp_lock_b));
  endtask

  // Drive one cycle of input at the falling edge, queue its expectation and
  // check it just after the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    in_valid = v.valid;
    in_code  = v.code;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkIdle(input string tag);
    cmp({tag, " out_valid"}, 32'(out_valid_a), 32'd0);
    cmp({tag, " out_index"}, 32'(out_index_a), 32'd0);
    cmp({tag, " code_err"},  32'(code_err_a),  32'd0);
    cmp({tag, " seq_err"},   32'(seq_err_a),   32'd0);
    cmp({tag, " locked"},    32'(locked_a),    32'd0);
    cmp({tag, " err_count"}, 32'(err_count_a), 32'd0);
    cmp({tag, " locked_lc1"}, 32'(locked_b),   32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    checkIdle("reset");
    reset = 1'b1;
  endtask

  task automatic runTable();
    foreach (tbl[i]) applyStimulus(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_code  = 4'b0000;
    repeat (2) @(posedge clk);
    doReset();

    // Basic decode, lock at the fifth word, code error, resync, sequence error
    tbl.push_back(mk(1, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 1, 2, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 1, 3, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1110, 1, 5, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0101, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0011, 1, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b1111, 1, 4, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 4'b1110, 1, 5, 0, 0, 0, 1, 2));
    runTable();

    // Gap with in_valid low (junk on in_code), holds, lock on the first step
    // for LOCK_COUNT=1, then wrap through 7 -> 0
    doReset();
    tbl.push_back(mk(1, 4'b0111, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1110, 1, 5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1100, 1, 6, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1000, 1, 7, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 1, 1, 0, 0, 1, 1, 0));
    runTable();

    // Saturation of err_count with 300 illegal words, then an idle cycle
    for (int i = 0; i < 300; i++) begin
      applyStimulus(mk(1, 4'b1010, 1, 0, 1, 0, 0, 0, (i + 1 > 255) ? 255 : i + 1));
    end
    applyStimulus(mk(0, 4'b0001, 0, 0, 0, 0, 0, 0, 255));

    // Build up err_count=5 and lock, then pulse reset between edges
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(1, 4'b1010, 1, 0, 1, 0, 0, 0, i + 1));
    end
    tbl.push_back(mk(1, 4'b0001, 1, 1, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, 4'b0011, 1, 2, 0, 0, 0, 1, 5));
    tbl.push_back(mk(1, 4'b0111, 1, 3, 0, 0, 0, 1, 5));
    tbl.push_back(mk(1, 4'b1111, 1, 4, 0, 0, 0, 1, 5));
    tbl.push_back(mk(1, 4'b1110, 1, 5, 0, 0, 1, 1, 5));
    runTable();

    // Still between edges here (1 ns after the rising edge)
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1 checkIdle("async reset low");
    #1 reset = 1'b1;
    #1 checkIdle("async reset released");

    // Reference was cleared, so a jump from phase 5 to 1 is no error
    tbl.push_back(mk(1, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 1, 2, 0, 0, 0, 1, 0));
    runTable();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
